// File: rtl/fram_arb_pkg.sv
// Shared encodings and owner selection for the frame read/write command arbiter.
// FRAM_ARB_RD_PRIO_EN: read always wins a tie instead of round-robin.
package fram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_BUSY = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_WR = 1'b0,
      OWN_RD = 1'b1
   } owner_t;

   localparam int NUM_REQ = 2;

   function automatic owner_t pick_owner(input logic wr_pend, input logic rd_pend,
                                         input owner_t last_grant);
      owner_t sel;
      if (wr_pend && rd_pend) begin
`ifdef FRAM_ARB_RD_PRIO_EN
         sel = OWN_RD;
`else
         sel = (last_grant == OWN_WR) ? OWN_RD : OWN_WR;
`endif
      end else if (rd_pend) begin
         sel = OWN_RD;
      end else begin
         sel = OWN_WR;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fram_arb_req_latch.sv
// Per-requester latch: holds one pending request (address/length) and a sticky
// overflow flag for requests that arrive while one is already pending.
module fram_arb_req_latch #(
   parameter int ADDR_WIDTH = 27,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  ddr_clk,
   input  logic                  ddr_rstn,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [LEN_WIDTH-1:0]  len_in,
   input  logic                  clr,
   output logic                  pending,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [LEN_WIDTH-1:0]  len,
   output logic                  ovf
);

   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  ovf_q, ovf_d;

   // A request arriving in the same cycle as the clear takes the freed slot.
   always_comb begin
      pend_d = pend_q;
      addr_d = addr_q;
      len_d  = len_q;
      ovf_d  = ovf_q;
      if (req && (!pend_q || clr)) begin
         pend_d = 1'b1;
         addr_d = addr_in;
         len_d  = len_in;
      end else begin
         if (clr) pend_d = 1'b0;
         if (req) ovf_d  = 1'b1;
      end
   end

   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         pend_q <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         addr_q <= addr_d;
         len_q  <= len_d;
         ovf_q  <= ovf_d;
      end
   end

   assign pending = pend_q;
   assign addr    = addr_q;
   assign len     = len_q;
   assign ovf     = ovf_q;

endmodule

// File: rtl/fram_rw_arb.sv
// Arbitrates the single DDR command port between the frame write and read paths.
// FRAM_ARB_RD_PRIO_EN: read wins every tie (see fram_arb_pkg::pick_owner).
module fram_rw_arb
   import fram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 27,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  ddr_clk,
   input  logic                  ddr_rstn,
   input  logic                  init_done,
   input  logic                  ddr_wreq,
   input  logic [ADDR_WIDTH-1:0] ddr_waddr,
   input  logic [LEN_WIDTH-1:0]  ddr_wr_len,
   output logic                  ddr_wrdy,
   output logic                  ddr_wdone,
   input  logic                  ddr_rreq,
   input  logic [ADDR_WIDTH-1:0] ddr_raddr,
   input  logic [LEN_WIDTH-1:0]  ddr_rd_len,
   output logic                  ddr_rrdy,
   output logic                  ddr_rdone,
   output logic                  cmd_valid,
   output logic                  cmd_we,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_ready,
   input  logic                  cmd_done,
   output logic                  wr_active,
   output logic                  rd_active,
   output logic [1:0]            req_ovf
);

   logic [NUM_REQ-1:0]    req_vec, pend_vec, clr_vec, ovf_vec;
   logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
   logic [LEN_WIDTH-1:0]  req_len  [NUM_REQ];
   logic [ADDR_WIDTH-1:0] lat_addr [NUM_REQ];
   logic [LEN_WIDTH-1:0]  lat_len  [NUM_REQ];

   // Index 0 is the write path, index 1 the read path (matches owner_t).
   assign req_vec     = {ddr_rreq, ddr_wreq};
   assign req_addr[0] = ddr_waddr;
   assign req_addr[1] = ddr_raddr;
   assign req_len[0]  = ddr_wr_len;
   assign req_len[1]  = ddr_rd_len;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         fram_arb_req_latch #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .LEN_WIDTH (LEN_WIDTH)
         ) u_latch (
            .ddr_clk (ddr_clk),
            .ddr_rstn(ddr_rstn),
            .req     (req_vec[gi]),
            .addr_in (req_addr[gi]),
            .len_in  (req_len[gi]),
            .clr     (clr_vec[gi]),
            .pending (pend_vec[gi]),
            .addr    (lat_addr[gi]),
            .len     (lat_len[gi]),
            .ovf     (ovf_vec[gi])
         );
      end
   endgenerate

   arb_state_t state_q, state_d;
   owner_t     owner_q, owner_d;
   owner_t     last_grant_q, last_grant_d;
   logic [1:0] rdy_q, rdy_d;
   logic [1:0] done_q, done_d;
   logic [1:0] owner_onehot;

   assign owner_onehot = (owner_q == OWN_RD) ? 2'b10 : 2'b01;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rdy_d        = 2'b00;
      done_d       = 2'b00;
      clr_vec      = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (init_done && (|pend_vec)) begin
               owner_d = pick_owner(pend_vec[0], pend_vec[1], last_grant_q);
               state_d = ST_ARB;
            end
         end
         ST_ARB: begin
            if (cmd_ready) begin
               rdy_d   = owner_onehot;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cmd_done) begin
               done_d       = owner_onehot;
               clr_vec      = owner_onehot;
               last_grant_d = owner_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_WR;
         last_grant_q <= OWN_WR;
         rdy_q        <= 2'b00;
         done_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rdy_q        <= rdy_d;
         done_q       <= done_d;
      end
   end

   // Command fields are forced to zero whenever no command is being offered.
   assign cmd_valid = (state_q == ST_ARB);
   assign cmd_we    = cmd_valid && (owner_q == OWN_WR);
   assign cmd_addr  = !cmd_valid ? '0 : (owner_q == OWN_RD) ? lat_addr[1] : lat_addr[0];
   assign cmd_len   = !cmd_valid ? '0 : (owner_q == OWN_RD) ? lat_len[1]  : lat_len[0];
   assign wr_active = (state_q != ST_IDLE) && (owner_q == OWN_WR);
   assign rd_active = (state_q != ST_IDLE) && (owner_q == OWN_RD);
   assign ddr_wrdy  = rdy_q[0];
   assign ddr_rrdy  = rdy_q[1];
   assign ddr_wdone = done_q[0];
   assign ddr_rdone = done_q[1];
   assign req_ovf   = ovf_vec;

endmodule
